// File: rtl/irq_vector_ctrl.sv
// Interrupt/vector controller feeding the CPU's INT and entryPoint inputs.
// Issues a boot vector after reset, latches rising edges on the request
// lines, grants the lowest-numbered unmasked pending request and waits for
// the CPU's end-of-interrupt before arbitrating again.
module irq_vector_ctrl #(
  parameter int unsigned NIRQ       = 4,
  parameter logic [31:0] BOOT_VEC   = 32'd128,
  parameter logic [31:0] VEC_BASE   = 32'd256,
  parameter logic [31:0] VEC_STRIDE = 32'd16,
  localparam int unsigned IW        = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  input  logic            eoi,
  output logic            INT,
  output logic [31:0]     entryPoint,
  output logic [IW-1:0]   active_id,
  output logic [NIRQ-1:0] pending,
  output logic            busy
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] edges;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] grant_clear;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [31:0]     grant_vec;

  logic            int_next;
  logic [31:0]     entry_next;
  logic [IW-1:0]   active_next;
  logic [NIRQ-1:0] pending_next;
  logic            busy_next;

  assign edges    = irq & ~irq_q;
  assign eligible = pending & ~mask;

  // The cycle right after any pulse (only possible after the boot pulse)
  // skips arbitration so INT can never be high two cycles in a row.
  assign grant_valid = (state == IDLE) && !INT && (|eligible);
  assign grant_vec   = VEC_BASE + (32'(grant_idx) * VEC_STRIDE);

  // Fixed priority: lowest eligible index wins, scanned from the top down.
  always_comb begin
    grant_idx = '0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        grant_idx = IW'(k);
      end
    end
  end

  // State register; reset always returns to BOOT so a new boot pulse follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: BOOT lasts one cycle, a grant enters SERVICE, eoi leaves it.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = IDLE;
      IDLE:    state_next = grant_valid ? SERVICE : IDLE;
      SERVICE: state_next = eoi ? IDLE : SERVICE;
      default: state_next = BOOT;
    endcase
  end

  // Output logic: next values of the registered outputs for each state.
  always_comb begin
    int_next    = 1'b0;
    entry_next  = entryPoint;
    active_next = active_id;
    busy_next   = busy;
    grant_clear = '0;
    case (state)
      BOOT: begin
        int_next   = 1'b1;
        entry_next = BOOT_VEC;
        busy_next  = 1'b0;
      end
      IDLE: begin
        if (grant_valid) begin
          int_next    = 1'b1;
          entry_next  = grant_vec;
          active_next = grant_idx;
          busy_next   = 1'b1;
          grant_clear = NIRQ'(1) << grant_idx;
        end
      end
      SERVICE: begin
        if (eoi) begin
          busy_next = 1'b0;
        end
      end
      default: begin
        busy_next = 1'b0;
      end
    endcase
    pending_next = (pending & ~grant_clear) | edges;
  end

  // Registered outputs, edge-detect history and mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      INT        <= 1'b0;
      entryPoint <= BOOT_VEC;
      active_id  <= '0;
      pending    <= '0;
      busy       <= 1'b0;
      mask       <= '0;
      irq_q      <= '0;
    end else begin
      INT        <= int_next;
      entryPoint <= entry_next;
      active_id  <= active_next;
      pending    <= pending_next;
      busy       <= busy_next;
      irq_q      <= irq;
      if (mask_we) begin
        mask <= mask_in;
      end
    end
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench for irq_vector_ctrl: a table of directed cycles,
// a few hand-written corner sequences and randomized traffic compared
// against a behavioural model.
module tb_irq_vector_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_in;
  logic        eoi;
  logic        INT;
  logic [31:0] entryPoint;
  logic [1:0]  active_id;
  logic [3:0]  pending;
  logic        busy;

  int compared = 0;
  int failed   = 0;

  irq_vector_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .eoi(eoi), .INT(INT), .entryPoint(entryPoint), .active_id(active_id),
    .pending(pending), .busy(busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_in;
    logic        eoi;
    logic        exp_int;
    logic [31:0] exp_entry;
    logic [1:0]  exp_active;
    logic [3:0]  exp_pend;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];

  // Behavioural reference state.
  bit          m_boot_owed;
  bit          m_serving;
  bit          m_int;
  logic [31:0] m_entry;
  logic [1:0]  m_active;
  logic [3:0]  m_pend;
  logic [3:0]  m_mask;
  logic [3:0]  m_prev_irq;
  logic        prev_int;

  function automatic vec_t mk(logic r, logic [3:0] i, logic mwe, logic [3:0] mi,
                              logic e, logic xi, logic [31:0] xe, logic [1:0] xa,
                              logic [3:0] xp, logic xb);
    vec_t v;
    v.rst = r; v.irq = i; v.mask_we = mwe; v.mask_in = mi; v.eoi = e;
    v.exp_int = xi; v.exp_entry = xe; v.exp_active = xa; v.exp_pend = xp;
    v.exp_busy = xb;
    return v;
  endfunction

  // One clock of the reference: rules applied to the inputs seen at the edge.
  task automatic modelStep();
    logic [3:0] new_edges;
    logic [3:0] elig;
    bit         had_int;
    if (rst) begin
      m_boot_owed = 1; m_serving = 0; m_int = 0; m_entry = 32'd128;
      m_active = 0; m_pend = 0; m_mask = 0; m_prev_irq = 0;
    end else begin
      new_edges  = irq & ~m_prev_irq;
      m_prev_irq = irq;
      had_int    = m_int;
      m_int      = 0;
      elig       = m_pend & ~m_mask;
      if (m_boot_owed) begin
        m_int = 1; m_entry = 32'd128; m_boot_owed = 0;
      end else if (m_serving) begin
        if (eoi) m_serving = 0;
      end else if (!had_int) begin
        for (int k = 0; k < 4; k++) begin
          if (elig[k] && !m_int) begin
            m_int     = 1;
            m_entry   = 32'd256 + 32'(k) * 32'd16;
            m_active  = 2'(k);
            m_serving = 1;
            m_pend[k] = 1'b0;
          end
        end
      end
      m_pend = m_pend | new_edges;
      if (mask_we) m_mask = mask_in;
    end
  endtask

  task automatic applyStimulus(logic r, logic [3:0] i, logic mwe, logic [3:0] mi, logic e);
    rst = r; irq = i; mask_we = mwe; mask_in = mi; eoi = e;
    prev_int = INT;
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic checkOutput(string tag, logic xi, logic [31:0] xe, logic [1:0] xa,
                             logic [3:0] xp, logic xb);
    compared++;
    if (INT !== xi || entryPoint !== xe || active_id !== xa || pending !== xp || busy !== xb) begin
      failed++;
      $display("[TB] FAIL %s: got INT=%0b entry=%0d active=%0d pending=%b busy=%0b, want INT=%0b entry=%0d active=%0d pending=%b busy=%0b",
               tag, INT, entryPoint, active_id, pending, busy, xi, xe, xa, xp, xb);
    end
  endtask

  // Model comparison plus the never-two-pulses-in-a-row rule.
  task automatic checkModel(string tag);
    checkOutput({tag, "_model"}, m_int, m_entry, m_active, m_pend, m_serving);
    compared++;
    if (prev_int === 1'b1 && INT === 1'b1) begin
      failed++;
      $display("[TB] FAIL %s_int_twice: got INT=1 after INT=1, want INT=0", tag);
    end
  endtask

  initial begin
    rst = 1; irq = 0; mask_we = 0; mask_in = 0; eoi = 0; prev_int = 0;
    m_boot_owed = 1; m_serving = 0; m_int = 0; m_entry = 128; m_active = 0;
    m_pend = 0; m_mask = 0; m_prev_irq = 0;

    //          rst irq    mwe min   eoi  INT entry  act pend   busy
    // boot
    vq.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 128, 0, 4'b0000, 0));
    vq.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 128, 0, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 128, 0, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 128, 0, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 128, 0, 4'b0000, 0));
    // single request on line 2
    vq.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0, 128, 0, 4'b0100, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 288, 2, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 288, 2, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 288, 2, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 288, 2, 4'b0000, 0));
    // lines 1 and 3 together: priority order, one idle cycle between pulses
    vq.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 0, 288, 2, 4'b1010, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 272, 1, 4'b1000, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 272, 1, 4'b1000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 304, 3, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 304, 3, 4'b0000, 0));
    // masked line 0 stays pending until unmasked
    vq.push_back(mk(0, 4'b0000, 1, 4'b0001, 0, 0, 304, 3, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 304, 3, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 304, 3, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0001, 1, 4'b0000, 0, 0, 304, 3, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 256, 0, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 256, 0, 4'b0000, 0));
    // eoi in IDLE is ignored; request while busy waits for eoi
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 256, 0, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 256, 0, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 256, 0, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0, 256, 0, 4'b0100, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 256, 0, 4'b0100, 1));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 256, 0, 4'b0100, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 288, 2, 4'b0000, 1));
    // reset mid-SERVICE with a pending request
    vq.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 288, 2, 4'b0010, 1));
    vq.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 128, 0, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 128, 0, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 128, 0, 4'b0000, 0));

    foreach (vq[n]) begin
      applyStimulus(vq[n].rst, vq[n].irq, vq[n].mask_we, vq[n].mask_in, vq[n].eoi);
      checkOutput($sformatf("vec%0d", n), vq[n].exp_int, vq[n].exp_entry,
                  vq[n].exp_active, vq[n].exp_pend, vq[n].exp_busy);
      checkModel($sformatf("vec%0d", n));
    end

    // Grant clear and a new edge on the same line: the new edge survives.
    applyStimulus(0, 4'b0000, 1, 4'b0001, 0); checkOutput("setwin_mask", 0, 128, 0, 4'b0000, 0);
    applyStimulus(0, 4'b0001, 0, 4'b0000, 0); checkOutput("setwin_latch", 0, 128, 0, 4'b0001, 0);
    applyStimulus(0, 4'b0000, 1, 4'b0000, 0); checkOutput("setwin_unmask", 0, 128, 0, 4'b0001, 0);
    applyStimulus(0, 4'b0001, 0, 4'b0000, 0); checkOutput("setwin_grant", 1, 256, 0, 4'b0001, 1);
    applyStimulus(0, 4'b0001, 0, 4'b0000, 1); checkOutput("setwin_eoi", 0, 256, 0, 4'b0001, 0);
    applyStimulus(0, 4'b0000, 0, 4'b0000, 0); checkOutput("setwin_regrant", 1, 256, 0, 4'b0000, 1);
    applyStimulus(0, 4'b0000, 0, 4'b0000, 1); checkOutput("setwin_done", 0, 256, 0, 4'b0000, 0);

    // Line already high at reset release counts as an edge; no back-to-back INT.
    applyStimulus(1, 4'b0001, 0, 4'b0000, 0); checkOutput("hot_reset", 0, 128, 0, 4'b0000, 0);
    applyStimulus(0, 4'b0001, 0, 4'b0000, 0); checkOutput("hot_boot", 1, 128, 0, 4'b0001, 0);
    applyStimulus(0, 4'b0001, 0, 4'b0000, 0); checkOutput("hot_gap", 0, 128, 0, 4'b0001, 0);
    checkModel("hot_gap");
    applyStimulus(0, 4'b0001, 0, 4'b0000, 0); checkOutput("hot_grant", 1, 256, 0, 4'b0000, 1);
    applyStimulus(0, 4'b0000, 0, 4'b0000, 1); checkOutput("hot_eoi", 0, 256, 0, 4'b0000, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      checkModel($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
Interrupt/vector controller that drives the single-cycle CPU's INT and entryPoint inputs, which the CPU's PC unit consumes to redirect fetch. It issues a boot vector after reset, then latches rising edges on NIRQ request lines, arbitrates them by fixed priority against a mask, and pulses INT with the selected vector. It then waits for the CPU's end-of-interrupt before issuing again.

Parameters:
NIRQ, 4, number of request lines (index width is 2 at the default).
BOOT_VEC, 128, entry point issued after reset.
VEC_BASE, 256, vector address of request 0.
VEC_STRIDE, 16, byte spacing between consecutive request vectors.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
irq  input  NIRQ  request lines; rising-edge sensitive.
mask_we  input  1  mask write strobe.
mask_in  input  NIRQ  new mask value; bit=1 blocks that line.
eoi  input  1  end-of-interrupt from the CPU, one-cycle strobe.
INT  output  1  registered one-cycle pulse; the CPU loads entryPoint into the PC.
entryPoint  output  32  vector address, registered.
active_id  output  2  index of the request in service.
pending  output  NIRQ  latched, unserviced requests.
busy  output  1  high while in SERVICE.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: INT=0, entryPoint=BOOT_VEC, active_id=0, pending=0, busy=0, mask=0 (all enabled), irq_q=0, state=BOOT.
- States: BOOT, IDLE, SERVICE.
- BOOT:
  - In the first clock with rst=0, INT<=1 and entryPoint<=BOOT_VEC.
  - Next state is IDLE.
  - Exactly one boot pulse per reset release.
- Edge detection:
  - irq_q<=irq every cycle.
  - pending[i]<=1 when irq[i]&~irq_q[i].
  - A line already high at reset release counts as an edge in the first cycle.
  - Edges are latched in every state.
- IDLE:
  - eligible = pending & ~mask.
  - If eligible is nonzero, take i = lowest set index.
  - At that edge: INT<=1, entryPoint<=VEC_BASE+i*VEC_STRIDE (32-bit, wraps mod 2^32), active_id<=i, pending[i]<=0, busy<=1, state<=SERVICE.
  - Otherwise INT<=0.
- SERVICE:
  - INT<=0 and no arbitration.
  - On eoi=1: busy<=0, state<=IDLE.
  - Arbitration resumes the following cycle, so there is at least one IDLE cycle between consecutive interrupt pulses.
- eoi in BOOT or IDLE is ignored.
- INT is high for exactly one cycle per issue and is never high in two consecutive cycles.
- entryPoint and active_id hold their last value between issues.
- Latency: irq rising at clock edge t sets pending after t. With IDLE and the line unmasked, INT=1 is visible after edge t+1.
- mask_we:
  - mask<=mask_in, effective from the next cycle.
  - Masked pending bits stay latched and are issued when unmasked.
- Simultaneous grant-clear and new edge on the same line: the set wins, and pending[i] stays 1.
- rst in any state, including mid-SERVICE: everything returns to reset values, pending and mask are cleared, and the boot pulse is reissued.

Test Plan:
1. rst=1 for 2 cycles, then 0 → INT=1 for exactly one cycle with entryPoint=128, busy=0; INT=0 thereafter while irq=0.
2. After boot, pulse irq[2] → INT pulses 2 cycles after the irq edge with entryPoint=288, active_id=2, busy=1, pending=0000; eoi → busy=0.
3. irq[1] and irq[3] rise in the same cycle → first INT has entryPoint=272, active_id=1, pending=1000; eoi → next INT has entryPoint=304, active_id=3, with one idle cycle between the pulses.
4. mask_in=0001 with mask_we, then irq[0] edge → no INT, pending=0001; write mask 0000 → INT with entryPoint=256 the cycle after unmask.
5. irq[2] edge while busy → no INT and pending=0100 until eoi, then INT with entryPoint=288; also check that eoi in IDLE causes no change.
6. rst asserted mid-SERVICE with pending=0010 → next cycle after release INT=1 with entryPoint=128, pending=0000, busy=0, active_id=0.
